// File: rtl/pipelined_barrel_shifter.sv
// Pipelined logarithmic barrel shifter with a valid/ready handshake on both sides.
// Row k shifts by 2**k when shamt[k] is set; rows are processed LSB first, and a
// register stage is placed after every ROWS_PER_REG rows.
//
// Ports:
//   clk, rst      clock (rising edge), synchronous active-high reset
//   in_valid      input beat valid
//   in_ready      input accepted this cycle (combinational from out_ready)
//   in_data       operand
//   in_shamt      shift amount 0..WIDTH-1
//   in_mode       00 SLL, 01 SRL, 10 SRA, 11 ROL
//   out_valid     result valid (last stage)
//   out_ready     downstream accepts result
//   out_data      shifted result (last stage register)
//   out_sticky    OR of every bit discarded by the shift (last stage register)
module pipelined_barrel_shifter #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned ROWS_PER_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_sticky
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);
    localparam int unsigned LATENCY = (SHAMT_W + ROWS_PER_REG - 1) / ROWS_PER_REG;
    localparam int unsigned LAST    = LATENCY - 1;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;

    localparam logic [WIDTH-1:0] ONES = '1;

    // Stage registers
    logic               r_valid  [LATENCY];
    logic [WIDTH-1:0]   r_data   [LATENCY];
    logic [SHAMT_W-1:0] r_shamt  [LATENCY];
    logic [1:0]         r_mode   [LATENCY];
    logic               r_sticky [LATENCY];

    // Per-stage inputs (previous stage or the input port) and row results
    logic               w_load       [LATENCY];
    logic               w_src_valid  [LATENCY];
    logic [WIDTH-1:0]   w_src_data   [LATENCY];
    logic [SHAMT_W-1:0] w_src_shamt  [LATENCY];
    logic [1:0]         w_src_mode   [LATENCY];
    logic               w_src_sticky [LATENCY];
    logic [WIDTH-1:0]   w_nxt_data   [LATENCY];
    logic               w_nxt_sticky [LATENCY];

    // Ready chain: a stage loads when empty or when its contents leave this cycle
    always_comb begin : ready_chain
        for (int unsigned i = 0; i < LATENCY; i++) begin
            w_load[i] = 1'b0;
        end
        w_load[LAST] = !r_valid[LAST] || out_ready;
        for (int i = int'(LAST) - 1; i >= 0; i--) begin
            w_load[i] = !r_valid[i] || w_load[i+1];
        end
    end

    assign in_ready = w_load[0];

    // Feed of each stage: input port for stage 0, previous register otherwise
    always_comb begin : stage_src
        w_src_valid[0]  = in_valid;
        w_src_data[0]   = in_data;
        w_src_shamt[0]  = in_shamt;
        w_src_mode[0]   = in_mode;
        w_src_sticky[0] = 1'b0;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            w_src_valid[i]  = r_valid[i-1];
            w_src_data[i]   = r_data[i-1];
            w_src_shamt[i]  = r_shamt[i-1];
            w_src_mode[i]   = r_mode[i-1];
            w_src_sticky[i] = r_sticky[i-1];
        end
    end

    // Shift rows owned by each stage; sticky collects bits pushed off the edge
    always_comb begin : shift_rows
        logic [WIDTH-1:0] d;
        logic             st;
        int unsigned      s;
        d  = '0;
        st = 1'b0;
        s  = 0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            d  = w_src_data[i];
            st = w_src_sticky[i];
            for (int unsigned k = 0; k < SHAMT_W; k++) begin
                if (((k / ROWS_PER_REG) == i) && w_src_shamt[i][k]) begin
                    s = 1 << k;
                    case (w_src_mode[i])
                        MODE_SLL: begin
                            st = st | (|(d & ~(ONES >> s)));
                            d  = d << s;
                        end
                        MODE_SRL: begin
                            st = st | (|(d & ~(ONES << s)));
                            d  = d >> s;
                        end
                        MODE_SRA: begin
                            // Sign bit is invariant under SRA, so d's MSB is the original one
                            st = st | (|(d & ~(ONES << s)));
                            d  = (d >> s) | (d[WIDTH-1] ? ~(ONES >> s) : '0);
                        end
                        default: begin
                            d = (d << s) | (d >> (WIDTH - s));
                        end
                    endcase
                end
            end
            w_nxt_data[i]   = d;
            w_nxt_sticky[i] = st;
        end
    end

    // Stage registers; payload only captured for valid beats
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                r_valid[i]  <= 1'b0;
                r_data[i]   <= '0;
                r_shamt[i]  <= '0;
                r_mode[i]   <= '0;
                r_sticky[i] <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                if (w_load[i]) begin
                    r_valid[i] <= w_src_valid[i];
                    if (w_src_valid[i]) begin
                        r_data[i]   <= w_nxt_data[i];
                        r_shamt[i]  <= w_src_shamt[i];
                        r_mode[i]   <= w_src_mode[i];
                        r_sticky[i] <= w_nxt_sticky[i];
                    end
                end
            end
        end
    end

    assign out_valid  = r_valid[LAST];
    assign out_data   = r_data[LAST];
    assign out_sticky = r_sticky[LAST];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (WIDTH=16, ROWS_PER_REG=1).
module tb_pipelined_barrel_shifter;

    localparam int unsigned W   = 16;
    localparam int unsigned SW  = 4;
    localparam int unsigned LAT = 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic         s;
    } exp_t;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data   = '0;
    logic [SW-1:0] in_shamt  = '0;
    logic [1:0]    in_mode   = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_sticky;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t held;
    logic hold_pend = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   n_pop = 0;

    pipelined_barrel_shifter #(.WIDTH(W), .ROWS_PER_REG(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sticky (out_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: shift inside a double-width word, the half that falls off is the sticky
    function automatic exp_t model(input logic [W-1:0] d, input logic [SW-1:0] sh, input logic [1:0] m);
        logic [2*W-1:0]        w;
        logic signed [2*W-1:0] ws;
        exp_t                  r;
        w  = '0;
        ws = '0;
        case (m)
            2'b00: begin
                w   = {{W{1'b0}}, d} << sh;
                r.d = w[W-1:0];
                r.s = |w[2*W-1:W];
            end
            2'b01: begin
                w   = {d, {W{1'b0}}} >> sh;
                r.d = w[2*W-1:W];
                r.s = |w[W-1:0];
            end
            2'b10: begin
                ws  = {d, {W{1'b0}}};
                ws  = ws >>> sh;
                w   = ws;
                r.d = w[2*W-1:W];
                r.s = |w[W-1:0];
            end
            default: begin
                w   = {d, d} << sh;
                r.d = w[2*W-1:W];
                r.s = 1'b0;
            end
        endcase
        return r;
    endfunction

    // Monitor: pops on every output transfer, checks stability under backpressure
    always begin
        @(negedge clk);
        #4;
        if (hold_pend) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_payload", 32'({out_data, out_sticky}), 32'({held.d, held.s}));
        end
        hold_pend = 1'b0;
        if (!rst && out_valid) begin
            if (!out_ready) begin
                hold_pend = 1'b1;
                held      = '{out_data, out_sticky};
            end else if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got data=%h sticky=%b, expected no output", out_data, out_sticky);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(mon_e.d));
                check("out_sticky", 32'(out_sticky), 32'(mon_e.s));
                n_pop++;
            end
        end
    end

    task automatic drive_cycle(input logic v, input logic [W-1:0] d, input logic [SW-1:0] sh,
                               input logic [1:0] m, input logic orr, input logic use_model,
                               input exp_t e, output logic took);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_shamt  = sh;
        in_mode   = m;
        out_ready = orr;
        #4;
        took = v && in_ready;
        if (took) exp_q.push_back(use_model ? model(d, sh, m) : e);
        @(posedge clk);
    endtask

    task automatic idle(input logic orr);
        logic took;
        drive_cycle(1'b0, '0, '0, 2'b00, orr, 1'b1, '0, took);
    endtask

    task automatic send(input logic [W-1:0] d, input logic [SW-1:0] sh, input logic [1:0] m, input exp_t e);
        logic took;
        took = 1'b0;
        for (int c = 0; c < 100 && !took; c++) begin
            drive_cycle(1'b1, d, sh, m, 1'b1, 1'b0, e, took);
        end
        if (!took) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 for 100 cycles, expected acceptance");
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) idle(1'b1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    logic [W-1:0]  dv_d  [10] = '{16'hF001, 16'h8010, 16'h8013, 16'h8000, 16'h8001,
                                  16'h8001, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5};
    logic [SW-1:0] dv_sh [10] = '{4'd4, 4'd4, 4'd4, 4'd15, 4'd1, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [1:0]    dv_m  [10] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
    logic [W-1:0]  dv_ed [10] = '{16'h0010, 16'hF801, 16'hF801, 16'h0001, 16'h0003,
                                  16'hC000, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5};
    logic          dv_es [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        logic took;
        int   acc;
        int   cyc;
        int   n;
        int   p0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #4;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sticky", 32'(out_sticky), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);

        // Single-beat latency
        p0 = n_pop;
        send(16'h00F1, 4'd4, 2'b00, '{16'h0F10, 1'b0});
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            idle(1'b1);
            if (n_pop > p0) begin
                n = i;
                break;
            end
        end
        check("latency", 32'(n), 32'(LAT));

        // Directed known answers
        for (int i = 0; i < 10; i++) send(dv_d[i], dv_sh[i], dv_m[i], '{dv_ed[i], dv_es[i]});
        drain();

        // Backpressure: fill with out_ready low, then release
        acc  = 0;
        took = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive_cycle(1'b1, W'(acc + 1), 4'd1, 2'b00, 1'b0, 1'b0, '{W'(2 * (acc + 1)), 1'b0}, took);
            if (took) acc++;
        end
        check("bp_accepted", 32'(acc), 32'(LAT));
        check("bp_in_ready_full", 32'(took), 32'd0);
        p0  = n_pop;
        cyc = 0;
        for (cyc = 0; cyc < 30; cyc++) begin
            if (acc < 8) begin
                drive_cycle(1'b1, W'(acc + 1), 4'd1, 2'b00, 1'b1, 1'b0, '{W'(2 * (acc + 1)), 1'b0}, took);
                if (took) acc++;
            end else begin
                idle(1'b1);
            end
            if (n_pop - p0 >= 8) break;
        end
        check("bp_burst_cycles", 32'(cyc + 1), 32'd8);
        drain();

        // Random traffic on both sides
        acc = 0;
        for (int c = 0; c < 20000 && acc < 1000; c++) begin
            drive_cycle(($urandom % 4) != 0, W'($urandom), SW'($urandom), 2'($urandom),
                        ($urandom % 3) != 0, 1'b1, '0, took);
            if (took) acc++;
        end
        check("rand_accepted", 32'(acc), 32'd1000);
        drain();

        // Reset with three beats in flight; reset also beats a concurrent in_valid
        p0 = n_pop;
        for (int j = 0; j < 3; j++) begin
            drive_cycle(1'b1, W'($urandom), SW'(j + 1), 2'b00, 1'b0, 1'b1, '0, took);
        end
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        in_shamt  = 4'd1;
        out_ready = 1'b1;
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #4;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_data", 32'(out_data), 32'd0);
        @(posedge clk);
        repeat (10) idle(1'b1);
        check("midrst_no_emit", 32'(n_pop - p0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Multi-mode, pipelined logarithmic barrel shifter built from SHAMT_W cascaded shift rows. Row k shifts by 2**k when shamt[k] is set. Pipeline registers are inserted every ROWS_PER_REG rows. A valid/ready elastic handshake on both sides lets the block sit between streaming datapath stages under backpressure.

Parameters:
WIDTH, 16, data width; power of two, >= 2
SHAMT_W, $clog2(WIDTH), shift-amount width and row count; derived, not overridden
ROWS_PER_REG, 1, shift rows per pipeline register; 1..SHAMT_W
LATENCY, ceil(SHAMT_W/ROWS_PER_REG), number of register stages; derived

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  input beat valid
in_ready  out  1  block accepts input this cycle
in_data  in  WIDTH  operand
in_shamt  in  SHAMT_W  shift amount 0..WIDTH-1
in_mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  WIDTH  shifted result
out_sticky  out  1  OR of all bits discarded by the shift

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all stage valid bits = 0, so out_valid=0. out_data=0 and out_sticky=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation: every in-flight beat is discarded and nothing is emitted. Reset wins over a simultaneous in_valid.
- Handshake:
  - A transfer occurs on a rising edge with valid&ready on that side.
  - in_data, in_shamt and in_mode are sampled only on an input transfer.
  - out_* are held stable while out_valid=1 and out_ready=0.
- Stage advance: stage i loads when it is empty, or when its downstream (stage i+1, or the output for the last stage) takes its contents in the same cycle.
  - in_ready = stage0 loads.
  - The ready chain is combinational from out_ready; there is no skid buffer.
- Bubbles: empty stages collapse. Capacity is LATENCY beats. With out_ready stuck low, at most LATENCY beats are accepted before in_ready=0.
- Latency: a beat accepted at edge t with out_ready held 1 gives out_valid=1 after edge t+LATENCY-1. Full throughput is 1 beat/cycle.
- Data flow: each stage register carries data, the remaining shamt bits, mode, sticky and valid. Rows process shamt LSB first.
- Row k, active when shamt[k]=1; s = 2**k:
  - SLL: d = d<<s, zero fill low s bits. sticky |= OR(d[WIDTH-1 -: s]) before the shift.
  - SRL: d = d>>s, zero fill high s bits. sticky |= OR(d[s-1:0]).
  - SRA: as SRL but fill with the original d[WIDTH-1]. sticky as SRL.
  - ROL: d = {d[WIDTH-1-s:0], d[WIDTH-1 -: s]}. sticky unchanged, so always 0.
- Inactive row: d passes unchanged and sticky is unchanged.
- shamt=0 in any mode: out_data = in_data, out_sticky = 0.
- Order is preserved; no beat is dropped or duplicated.
- Output fields are driven from the last register stage, with no combinational path from in_* to out_*.
- Simultaneous output pop and input push when full: both occur in the same cycle and occupancy is unchanged.

Test Plan:
- WIDTH=16, ROWS_PER_REG=1 (LATENCY=4), out_ready=1. Single SLL beat in_data=0x00F1, shamt=4 accepted at edge 0 -> out_valid=1 after edge 3, out_data=0x0F10, sticky=0. Then 0xF001, shamt=4 -> 0x0010, sticky=1.
- SRA 0x8010 shamt 4 -> 0xF801 sticky 0. SRA 0x8013 shamt 4 -> 0xF801 sticky 1. SRL 0x8000 shamt 15 -> 0x0001 sticky 0.
- ROL 0x8001 shamt 1 -> 0x0003. ROL 0x8001 shamt 15 -> 0xC000. Both sticky 0. Any mode with shamt 0 on 0xA5A5 -> 0xA5A5.
- Back-to-back stream of 8 SLL-by-1 beats 1..8 with out_ready low for cycles 5-9:
  - exactly 4 beats are held;
  - in_ready=0 while full;
  - outputs 2,4,...,16 appear in order with no gaps once out_ready=1.
- Random valid/ready toggling on both sides, 1000 beats, all modes, against a reference model -> all data and sticky match, order kept.
- rst asserted for one cycle with 3 beats in flight -> out_valid=0 next cycle, none of the 3 beats ever emitted, in_ready=1.
